rmii_rx_frame_check: RTL and testbench
======================================

// Module: rmii_rx_frame_check
// PURPOSE
//  - Sits directly downstream of the RMII MAC receiver. Consumes its 2-bit AXI stream (dibits after SFD).
//  - Packs dibits into bytes, checks CRC-32, enforces length limits and strips the 4-byte FCS.
//  - Emits an 8-bit AXI stream. tuser is set on the tlast beat of every bad frame.
// PARAMETERS
//  MIN_FRAME  64    minimum frame length in bytes, FCS included; shorter -> error
//  MAX_FRAME  1518  maximum frame length in bytes, FCS included; longer -> error
// PORTS
//  clock          in   1   single clock, 50 MHz
//  arst_n         in   1   asynchronous reset, active low
//  s_axi_tvalid   in   1   upstream dibit valid
//  s_axi_tlast    in   1   upstream last dibit
//  s_axi_tdata    in   2   upstream dibit, first-received dibit = byte bits [1:0]
//  s_axi_tuser    in   1   upstream error flag
//  s_axi_tready   out  1   upstream ready
//  m_axi_tvalid   out  1   byte valid
//  m_axi_tlast    out  1   last payload byte (FCS already removed)
//  m_axi_tdata    out  8   payload byte
//  m_axi_tuser    out  1   frame error; meaningful only when tlast=1
//  m_axi_tready   in   1   downstream ready
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset: all m_axi_* = 0, s_axi_tready = 0 during reset and 1 from the first clock after release.
//    State = IDLE, counters and CRC cleared. Reset mid-frame discards the frame silently.
//  - Packing: a 2-bit dibit counter. Byte = {d3,d2,d1,d0}. A byte completes on the 4th accepted dibit.
//  - CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF.
//    - Updated once per completed byte, over all bytes including the FCS.
//    - Good frame iff the final register equals residue 0xDEBB20E3.
//  - FCS strip: 5-byte shift buffer.
//    - A byte is moved to the output register only when a 6th byte completes.
//    - At tlast, the oldest buffered byte is the last payload byte; the other 4 are the FCS and are dropped.
//  - Output register: 1 entry, standard valid/ready.
//    - m_axi_tvalid holds until m_axi_tready. Data and flags are stable while valid && !ready.
//  - Overrun: a byte must move to the output register while it is valid && !ready.
//    - Set the sticky error bit and drop the new byte.
//    - Bytes already in the output register are never overwritten.
//  - Byte counter: 11 bits, saturates at 2047.
//  - Error sources, OR-ed into m_axi_tuser at tlast:
//    - upstream s_axi_tuser on any beat;
//    - CRC mismatch;
//    - byte count < MIN_FRAME or > MAX_FRAME;
//    - tlast with dibit counter != 3 (partial byte);
//    - overrun.
//  - Runt: tlast with fewer than 5 bytes buffered -> emit one beat tdata=0x00, tlast=1, tuser=1.
//  - FSM:
//    - IDLE -> FILL on the first accepted beat.
//    - FILL (no output) -> STREAM once 5 bytes are buffered.
//    - FILL/STREAM -> EOF on an accepted beat with s_axi_tlast.
//    - EOF: s_axi_tready=0. Load the final byte with tlast/tuser once the output register is empty or being accepted.
//    - EOF -> IDLE when that final beat is accepted. Clear counters, CRC and sticky error.
//  - Latency: a payload byte appears 1 cycle after the dibit completing the 6th-later byte. Last byte: 1 cycle after tlast, or later under backpressure.
//  - Simultaneous: byte completion and output acceptance in the same cycle is legal; it is not an overrun.
// CONFIGURATION
//  RMII_RX_FRAME_CHECK_STATS_EN defined:
//    - Adds outputs stat_good[31:0] and stat_bad[31:0], each reset to 0.
//    - Incremented in the cycle the final beat is accepted with tuser=0 or 1 respectively. Wrap at 2^32.
//  Not defined: the ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  - Package rmii_pkg:
//    - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE;
//    - ETH_MIN_FRAME, ETH_MAX_FRAME;
//    - the FSM state enum;
//    - function crc32_d8(crc, byte).
//  - Sub-module crc32_d8_reg: byte-wide CRC register with clear/enable and an is_residue output.
//    Instantiated once.
// TESTING
//  1. Valid 64-byte frame with correct FCS, m_axi_tready=1 -> 60 beats, tlast on beat 60, tuser=0.
//  2. Same frame with one payload bit flipped -> 60 beats, tuser=1 on beat 60.
//  3. 3-byte frame -> single beat 0x00, tlast=1, tuser=1. 1519-byte good-CRC frame -> tuser=1 on the last beat.
//  4. m_axi_tready=0 for 8 cycles mid-frame -> overrun, output never corrupted, tuser=1.
//     m_axi_tready=0 for 3 cycles -> no error.
//  5. tlast after 257 dibits -> tuser=1. Upstream tuser on the last beat -> tuser=1.
//     Reset asserted mid-frame -> outputs 0, next good frame passes clean.
//  6. With STATS_EN: scenarios 1 then 2 -> stat_good=1, stat_bad=1.

Source files
------------

// File: rtl/rmii_rx_frame_check_pkg.sv
// Shared constants, FSM state and byte-wide CRC-32 step
// for the RMII receive frame checker.
package rmii_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam int ETH_MIN_FRAME = 64;
    localparam int ETH_MAX_FRAME = 1518;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_EOF
    } state_t;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_d8(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_rx_frame_check_if.sv
// AXI-stream style bundle: tvalid/tready/tdata/tlast/tuser.
// master drives the payload, slave drives tready.
interface rmii_rx_frame_check_if #(
    parameter int DW = 8
) ();
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tuser;

    modport master (
        output tvalid, tdata, tlast, tuser,
        input  tready
    );
    modport slave (
        input  tvalid, tdata, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/rmii_rx_frame_check_crc32_d8_reg.sv
// Byte-wide CRC-32 register with clear/enable.
// Ports: clock, arst_n, clr, en, data[7:0] in; is_residue out.
module crc32_d8_reg
    import rmii_pkg::*;
(
    input  logic       clock,
    input  logic       arst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic       is_residue
);

    logic [31:0] crc_q;

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            crc_q <= CRC32_INIT;
        end else if (clr) begin
            crc_q <= CRC32_INIT;
        end else if (en) begin
            crc_q <= crc32_d8(crc_q, data);
        end
    end

    assign is_residue = (crc_q == CRC32_RESIDUE);

endmodule

// File: rtl/rmii_rx_frame_check.sv
// Packs RMII dibits into bytes, checks CRC/length, strips FCS.
// Ports: clock, arst_n, s_axi (2-bit slave), m_axi (8-bit master);
// with RMII_RX_FRAME_CHECK_STATS_EN also stat_good/stat_bad.
module rmii_rx_frame_check
    import rmii_pkg::*;
#(
    parameter int MIN_FRAME = ETH_MIN_FRAME,
    parameter int MAX_FRAME = ETH_MAX_FRAME
) (
    input  logic                         clock,
    input  logic                         arst_n,
    rmii_rx_frame_check_if.slave         s_axi,
    rmii_rx_frame_check_if.master        m_axi
`ifdef RMII_RX_FRAME_CHECK_STATS_EN
    ,
    output logic [31:0]                  stat_good,
    output logic [31:0]                  stat_bad
`endif
);

    localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_L = 11'(MAX_FRAME);

    state_t         state_q, state_d;
    logic           run_q;
    logic [1:0]     dcnt_q;
    logic [5:0]     sh_q;
    logic [4:0][7:0] buf_q;
    logic [10:0]    bcnt_q;
    logic           err_q;
    logic           fin_q;
    logic           o_valid_q, o_last_q, o_user_q;
    logic [7:0]     o_data_q;

    logic       s_rdy, acc, byte_done, out_free;
    logic       move, overrun, eof_load, final_acc;
    logic       crc_ok, runt, frame_err;
    logic [7:0] new_byte;

    assign new_byte  = {s_axi.tdata[1:0], sh_q};
    assign runt      = (bcnt_q < 11'd5);
    assign frame_err = err_q || !crc_ok
                     || (bcnt_q < MIN_L)
                     || (bcnt_q > MAX_L);

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    state_d = s_axi.tlast ? ST_EOF : ST_FILL;
                end
            end
            ST_FILL: begin
                if (acc && s_axi.tlast) begin
                    state_d = ST_EOF;
                end else if (!runt) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (acc && s_axi.tlast) begin
                    state_d = ST_EOF;
                end
            end
            ST_EOF: begin
                if (final_acc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_rdy     = run_q && (state_q != ST_EOF);
        acc       = s_axi.tvalid && s_rdy;
        byte_done = acc && (dcnt_q == 2'd3);
        out_free  = !o_valid_q || m_axi.tready;
        move      = byte_done && (state_q == ST_STREAM);
        overrun   = move && !out_free;
        eof_load  = (state_q == ST_EOF) && !fin_q && out_free;
        // fin_q means the final beat sits in the output register.
        final_acc = (state_q == ST_EOF) && fin_q && m_axi.tready;
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            run_q  <= 1'b0;
            dcnt_q <= '0;
            sh_q   <= '0;
            buf_q  <= '0;
            bcnt_q <= '0;
            err_q  <= 1'b0;
            fin_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (final_acc) begin
                dcnt_q <= '0;
                bcnt_q <= '0;
                err_q  <= 1'b0;
                fin_q  <= 1'b0;
            end else begin
                if (acc) begin
                    dcnt_q <= dcnt_q + 2'd1;
                    sh_q   <= {s_axi.tdata[1:0], sh_q[5:2]};
                end
                if (byte_done) begin
                    // buf_q[4] is the oldest byte once five are held.
                    buf_q <= {buf_q[3:0], new_byte};
                    if (bcnt_q != 11'h7FF) begin
                        bcnt_q <= bcnt_q + 11'd1;
                    end
                end
                err_q <= err_q
                       || (acc && s_axi.tuser)
                       || (acc && s_axi.tlast && !byte_done)
                       || overrun;
                if (eof_load) begin
                    fin_q <= 1'b1;
                end
            end
        end
    end

    // On overrun the oldest byte is dropped; the held beat stays put.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            o_user_q  <= 1'b0;
        end else if (eof_load) begin
            o_valid_q <= 1'b1;
            o_data_q  <= runt ? 8'h00 : buf_q[4];
            o_last_q  <= 1'b1;
            o_user_q  <= frame_err || runt;
        end else if (move && out_free) begin
            o_valid_q <= 1'b1;
            o_data_q  <= buf_q[4];
            o_last_q  <= 1'b0;
            o_user_q  <= 1'b0;
        end else if (m_axi.tready) begin
            o_valid_q <= 1'b0;
        end
    end

    crc32_d8_reg u_crc (
        .clock      (clock),
        .arst_n     (arst_n),
        .clr        (final_acc),
        .en         (byte_done),
        .data       (new_byte),
        .is_residue (crc_ok)
    );

    assign s_axi.tready = s_rdy;
    assign m_axi.tvalid = o_valid_q;
    assign m_axi.tdata  = o_data_q;
    assign m_axi.tlast  = o_last_q;
    assign m_axi.tuser  = o_user_q;

`ifdef RMII_RX_FRAME_CHECK_STATS_EN
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            stat_good <= '0;
            stat_bad  <= '0;
        end else if (final_acc) begin
            if (o_user_q) begin
                stat_bad <= stat_bad + 32'd1;
            end else begin
                stat_good <= stat_good + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rmii_rx_frame_check.sv
// Directed bench for rmii_rx_frame_check.
// Builds frames with a bitwise CRC model and checks output beats.
module tb_rmii_rx_frame_check;

    logic clock = 1'b0;
    logic arst_n = 1'b0;

    always #10 clock = ~clock;

    rmii_rx_frame_check_if #(.DW(2)) s_if ();
    rmii_rx_frame_check_if #(.DW(8)) m_if ();

`ifdef RMII_RX_FRAME_CHECK_STATS_EN
    logic [31:0] stat_good, stat_bad;
`endif

    rmii_rx_frame_check dut (
        .clock  (clock),
        .arst_n (arst_n),
        .s_axi  (s_if),
        .m_axi  (m_if)
`ifdef RMII_RX_FRAME_CHECK_STATS_EN
        ,
        .stat_good (stat_good),
        .stat_bad  (stat_bad)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c,
                                            input logic [7:0] b);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    logic [7:0] frm[$];
    logic [7:0] rx_q[$];
    bit   done = 0;
    int   n_last = 0;
    logic u_last = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = 0;

    always @(negedge clock) begin
        if (prev_stall) begin
            chk("hold_valid", 32'(m_if.tvalid), 1);
            chk("hold_data", 32'(m_if.tdata), 32'(prev_data));
        end
        prev_stall = arst_n && m_if.tvalid && !m_if.tready;
        prev_data = m_if.tdata;
        if (arst_n && m_if.tvalid && m_if.tready && !done) begin
            rx_q.push_back(m_if.tdata);
            if (m_if.tlast) begin
                done = 1;
                n_last = rx_q.size();
                u_last = m_if.tuser;
            end
        end
    end

    task automatic build(input int nbytes, input int seed);
        logic [31:0] c;
        logic [7:0] b;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < nbytes - 4; i++) begin
            b = 8'((i * 13 + seed) & 255);
            frm.push_back(b);
            c = crc_bit(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            frm.push_back(c[8*k +: 8]);
        end
    endtask

    task automatic put(input logic [1:0] d, input logic l,
                       input logic u);
        int n;
        s_if.tvalid = 1'b1;
        s_if.tdata = d;
        s_if.tlast = l;
        s_if.tuser = u;
        n = 0;
        @(negedge clock);
        while (!s_if.tready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("in_timeout", 0, 1);
        @(posedge clock);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
    endtask

    task automatic send(input bit extra, input bit ulast);
        logic [7:0] b;
        logic l;
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i];
            for (int k = 0; k < 4; k++) begin
                l = !extra && (i == frm.size() - 1) && (k == 3);
                put(b[2*k +: 2], l, l && ulast);
            end
        end
        if (extra) put(2'b01, 1'b1, ulast);
    endtask

    task automatic start();
        rx_q.delete();
        done = 0;
        n_last = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (!done) chk("out_timeout", 0, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    function automatic int data_errs(input int nb);
        int e;
        e = 0;
        for (int i = 0; i < nb && i < rx_q.size(); i++) begin
            if (rx_q[i] !== frm[i]) e++;
        end
        return e;
    endfunction

    task automatic stall(input int after, input int len);
        repeat (after) @(posedge clock);
        #1 m_if.tready = 1'b0;
        repeat (len) @(posedge clock);
        #1 m_if.tready = 1'b1;
    endtask

    initial begin
        s_if.tvalid = 0;
        s_if.tdata = 0;
        s_if.tlast = 0;
        s_if.tuser = 0;
        m_if.tready = 1;
        #35;
        chk("rst_m_valid", 32'(m_if.tvalid), 0);
        chk("rst_m_data", 32'(m_if.tdata), 0);
        chk("rst_m_last", 32'(m_if.tlast), 0);
        chk("rst_m_user", 32'(m_if.tuser), 0);
        chk("rst_s_ready", 32'(s_if.tready), 0);
        arst_n = 1;
        @(posedge clock);
        #1;
        chk("ready_after_rst", 32'(s_if.tready), 1);

        build(64, 1);
        start();
        send(0, 0);
        wait_done();
        chk("good_beats", n_last, 60);
        chk("good_user", 32'(u_last), 0);
        chk("good_data", data_errs(60), 0);

        build(64, 1);
        frm[10] = frm[10] ^ 8'h08;
        start();
        send(0, 0);
        wait_done();
        chk("crc_beats", n_last, 60);
        chk("crc_user", 32'(u_last), 1);
        chk("crc_data", data_errs(60), 0);
`ifdef RMII_RX_FRAME_CHECK_STATS_EN
        chk("stat_good", stat_good, 1);
        chk("stat_bad", stat_bad, 1);
`endif

        frm.delete();
        frm.push_back(8'h5A);
        frm.push_back(8'hC3);
        frm.push_back(8'h0F);
        start();
        send(0, 0);
        wait_done();
        chk("runt_beats", n_last, 1);
        chk("runt_data", 32'(rx_q[0]), 0);
        chk("runt_user", 32'(u_last), 1);

        build(1519, 5);
        start();
        send(0, 0);
        wait_done();
        chk("long_beats", n_last, 1515);
        chk("long_user", 32'(u_last), 1);
        chk("long_data", data_errs(1515), 0);

        build(64, 7);
        start();
        fork
            send(0, 0);
            stall(100, 8);
        join
        wait_done();
        chk("ovr_user", 32'(u_last), 1);
        chk("ovr_dropped", 32'(n_last < 60), 1);

        build(64, 9);
        start();
        fork
            send(0, 0);
            stall(100, 3);
        join
        wait_done();
        chk("bp3_beats", n_last, 60);
        chk("bp3_user", 32'(u_last), 0);
        chk("bp3_data", data_errs(60), 0);

        build(64, 11);
        start();
        send(1, 0);
        wait_done();
        chk("part_beats", n_last, 60);
        chk("part_user", 32'(u_last), 1);
        chk("part_data", data_errs(60), 0);

        build(64, 13);
        start();
        send(0, 1);
        wait_done();
        chk("uerr_beats", n_last, 60);
        chk("uerr_user", 32'(u_last), 1);

        build(64, 15);
        start();
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < 4; k++) begin
                put(frm[i][2*k +: 2], 1'b0, 1'b0);
            end
        end
        @(negedge clock);
        arst_n = 0;
        #3;
        chk("mid_rst_valid", 32'(m_if.tvalid), 0);
        chk("mid_rst_data", 32'(m_if.tdata), 0);
        chk("mid_rst_ready", 32'(s_if.tready), 0);
        @(negedge clock);
        arst_n = 1;
        build(64, 17);
        start();
        send(0, 0);
        wait_done();
        chk("post_rst_beats", n_last, 60);
        chk("post_rst_user", 32'(u_last), 0);
        chk("post_rst_data", data_errs(60), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
